// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture window block: FSM state
// encoding, pixel format widths, default crop window and the byte-pair
// packing helper used by the pixel assembler.
package cam_pkg;

  // Capture FSM states.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    FRAME      = 2'd2
  } cam_state_e;

  // Output pixel formats (width of the packed pixel).
  localparam int RGB444_W = 12;
  localparam int RGB565_W = 16;

  // Default crop window, in source pixels / lines.
  localparam int DEF_X_START = 0;
  localparam int DEF_WIN_W   = 320;
  localparam int DEF_Y_START = 0;
  localparam int DEF_WIN_H   = 240;

  // Width of the frame-skip count input.
  localparam int SKIP_W = 4;

  // Combine the two camera bytes of one pixel. RGB565 keeps both bytes;
  // RGB444 keeps only the low nibble of the first byte (xxxxRRRR GGGGBBBB).
  function automatic logic [15:0] pack_pixel(input logic [7:0] hi,
                                             input logic [7:0] lo,
                                             input int         width);
    logic [15:0] px;
    if (width == RGB565_W) begin
      px = {hi, lo};
    end else begin
      px = {4'h0, hi[3:0], lo};
    end
    return px;
  endfunction

endpackage

// File: rtl/cam_capture_window_if.sv
// Byte-to-pixel stream between the capture control logic and the pixel
// assembler.
//
// Handshake: byte_en is a per-cycle qualifier for byte_data; there is no
// ready, the assembler consumes every qualified byte. pix_valid is a
// one-cycle strobe that is high in the same cycle as the second byte of a
// pair, with pix_data valid only while pix_valid is high. Dropping byte_en
// restarts pairing from the first byte.
interface cam_capture_window_if #(
  parameter int DATA_WIDTH = 12
) ();

  logic                  byte_en;
  logic [7:0]            byte_data;
  logic                  pix_valid;
  logic [DATA_WIDTH-1:0] pix_data;

  // Control side: supplies bytes, receives assembled pixels.
  modport master (
    output byte_en,
    output byte_data,
    input  pix_valid,
    input  pix_data
  );

  // Assembler side.
  modport slave (
    input  byte_en,
    input  byte_data,
    output pix_valid,
    output pix_data
  );

endinterface

// File: rtl/cam_pixel_pack.sv
// Byte-pair assembler: toggles a phase bit on every qualified byte, latches
// the first (high) byte and presents the packed pixel alongside the second
// byte. A gap in byte_en discards a pending odd byte.
module cam_pixel_pack
  import cam_pkg::*;
#(
  parameter int DATA_WIDTH = RGB444_W
) (
  input  logic clk,
  input  logic reset_n,
  cam_capture_window_if.slave bus
);

  logic       phase_q;
  logic       phase_d;
  logic [7:0] hi_q;
  logic [7:0] hi_d;

  // Next phase and high-byte latch; phase returns to 0 whenever bytes stop.
  always_comb begin
    phase_d = 1'b0;
    hi_d    = hi_q;
    if (bus.byte_en) begin
      phase_d = ~phase_q;
      if (!phase_q) begin
        hi_d = bus.byte_data;
      end
    end
  end

  // Pixel is complete when a byte arrives in phase 1.
  always_comb begin
    bus.pix_valid = bus.byte_en & phase_q;
    bus.pix_data  = DATA_WIDTH'(pack_pixel(hi_q, bus.byte_data, DATA_WIDTH));
  end

  // Phase and high-byte registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= 1'b0;
      hi_q    <= 8'h00;
    end else begin
      phase_q <= phase_d;
      hi_q    <= hi_d;
    end
  end

endmodule

// File: rtl/cam_capture_window.sv
// Camera capture with crop window. Tracks frames via VSYNC edges, assembles
// byte pairs into RGB444/RGB565 pixels, counts source pixels/lines and emits
// a registered write strobe with window-relative address for pixels inside
// the crop window. Signals the end of every captured frame.
//
// Optional feature macro: CAM_CAPTURE_FRAME_SKIP_EN adds i_skip and captures
// one frame out of every (i_skip + 1).
module cam_capture_window
  import cam_pkg::*;
#(
  parameter int DATA_WIDTH = RGB444_W,
  parameter int CAM_LINE   = 9,
  parameter int CAM_PIXEL  = 10,
  parameter int X_START    = DEF_X_START,
  parameter int WIN_W      = DEF_WIN_W,
  parameter int Y_START    = DEF_Y_START,
  parameter int WIN_H      = DEF_WIN_H
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_enable,
  input  logic                  i_vs,
  input  logic                  i_hs,
  input  logic [7:0]            i_data,
`ifdef CAM_CAPTURE_FRAME_SKIP_EN
  input  logic [SKIP_W-1:0]     i_skip,
`endif
  output logic [DATA_WIDTH-1:0] o_data_wr,
  output logic                  we,
  output logic [CAM_LINE-1:0]   o_line,
  output logic [CAM_PIXEL-1:0]  o_pixel,
  output logic                  o_frame_done,
  output logic                  o_busy
);

  if (DATA_WIDTH != RGB444_W && DATA_WIDTH != RGB565_W) begin : g_bad_width
    $error("cam_capture_window: DATA_WIDTH must be 12 (RGB444) or 16 (RGB565)");
  end

  // FSM and frame bookkeeping.
  cam_state_e state_q;
  logic       busy_q;
  logic       done_q;
  logic       cap_q;     // current frame is captured (not skipped)
`ifdef CAM_CAPTURE_FRAME_SKIP_EN
  logic [SKIP_W-1:0] skip_cnt_q;
`endif

  // Sync edge detection.
  logic vs_q, vs_d;
  logic hs_q, hs_d;
  logic vs_fall, vs_rise, hs_fall;
  logic in_frame;
  logic frame_entry;

  // Source counters.
  logic [CAM_PIXEL-1:0] pix_cnt_q, pix_cnt_d;
  logic [CAM_LINE-1:0]  line_cnt_q, line_cnt_d;
  logic                 pix_sat, line_sat;
  logic                 x_hit, y_hit, wr_hit;

  // Registered write port.
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CAM_LINE-1:0]   line_q, line_d;
  logic [CAM_PIXEL-1:0]  pixel_q, pixel_d;

  cam_capture_window_if #(.DATA_WIDTH(DATA_WIDTH)) pack_bus ();

  cam_pixel_pack #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_pack (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (pack_bus.slave)
  );

  // Sync edges and byte qualification. The cycle where VSYNC rises ends the
  // frame, so a byte seen then is not assembled (aborts a partial pixel).
  always_comb begin
    vs_d               = i_vs;
    hs_d               = i_hs;
    vs_fall            = vs_q & ~i_vs;
    vs_rise            = ~vs_q & i_vs;
    hs_fall            = hs_q & ~i_hs;
    in_frame           = (state_q == FRAME);
    frame_entry        = (state_q == WAIT_FRAME) & i_enable & vs_fall;
    pack_bus.byte_en   = in_frame & i_hs & ~vs_rise;
    pack_bus.byte_data = i_data;
  end

  // Window compare and saturation guard for the pixel completing this cycle.
  always_comb begin
    pix_sat  = (pix_cnt_q == '1);
    line_sat = (line_cnt_q == '1);
    x_hit    = (int'(pix_cnt_q) >= X_START) &&
               (int'(pix_cnt_q) <= X_START + WIN_W - 1);
    y_hit    = (int'(line_cnt_q) >= Y_START) &&
               (int'(line_cnt_q) <= Y_START + WIN_H - 1);
    wr_hit   = pack_bus.pix_valid & cap_q & ~pix_sat & ~line_sat & x_hit & y_hit;
  end

  // Saturating source counters: pixel counts completed pixels within a line,
  // line counts HREF falling edges within a frame.
  always_comb begin
    pix_cnt_d  = pix_cnt_q;
    line_cnt_d = line_cnt_q;
    if (!in_frame || !i_hs) begin
      pix_cnt_d = '0;
    end else if (pack_bus.pix_valid && !pix_sat) begin
      pix_cnt_d = pix_cnt_q + CAM_PIXEL'(1);
    end
    if (frame_entry) begin
      line_cnt_d = '0;
    end else if (in_frame && hs_fall && !line_sat) begin
      line_cnt_d = line_cnt_q + CAM_LINE'(1);
    end
  end

  // Write port: strobe for one cycle, data/address hold between writes.
  always_comb begin
    we_d    = wr_hit;
    data_d  = data_q;
    line_d  = line_q;
    pixel_d = pixel_q;
    if (wr_hit) begin
      data_d  = pack_bus.pix_data;
      line_d  = CAM_LINE'(int'(line_cnt_q) - Y_START);
      pixel_d = CAM_PIXEL'(int'(pix_cnt_q) - X_START);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_q       <= 1'b0;
      hs_q       <= 1'b0;
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
      we_q       <= 1'b0;
      data_q     <= '0;
      line_q     <= '0;
      pixel_q    <= '0;
    end else begin
      vs_q       <= vs_d;
      hs_q       <= hs_d;
      pix_cnt_q  <= pix_cnt_d;
      line_cnt_q <= line_cnt_d;
      we_q       <= we_d;
      data_q     <= data_d;
      line_q     <= line_d;
      pixel_q    <= pixel_d;
    end
  end

  // Frame FSM with registered busy/done. Enable is only looked at outside
  // FRAME, so a frame in progress always runs to its VSYNC rise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cap_q      <= 1'b0;
`ifdef CAM_CAPTURE_FRAME_SKIP_EN
      skip_cnt_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_enable) begin
            state_q <= WAIT_FRAME;
          end
        end
        WAIT_FRAME: begin
          if (!i_enable) begin
            state_q <= IDLE;
          end else if (vs_fall) begin
            state_q <= FRAME;
`ifdef CAM_CAPTURE_FRAME_SKIP_EN
            // Capture when the skip count has run out, then reload it.
            if (skip_cnt_q == '0) begin
              cap_q      <= 1'b1;
              busy_q     <= 1'b1;
              skip_cnt_q <= i_skip;
            end else begin
              cap_q      <= 1'b0;
              busy_q     <= 1'b0;
              skip_cnt_q <= skip_cnt_q - SKIP_W'(1);
            end
`else
            cap_q  <= 1'b1;
            busy_q <= 1'b1;
`endif
          end
        end
        FRAME: begin
          if (vs_rise) begin
            done_q  <= cap_q;
            busy_q  <= 1'b0;
            state_q <= i_enable ? WAIT_FRAME : IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_data_wr    = data_q;
  assign we           = we_q;
  assign o_line       = line_q;
  assign o_pixel      = pixel_q;
  assign o_frame_done = done_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_cam_capture_window.sv
// Directed bench for cam_capture_window: an RGB444 instance with the default
// window and an RGB565 instance cropped to source pixels 2..3 share one
// camera stimulus; a negedge monitor scores every write against expected
// queues. Also exercises the pixel assembler directly through its interface.
module tb_cam_capture_window;
  import cam_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       i_enable;
  logic       i_vs;
  logic       i_hs;
  logic [7:0] i_data;
  logic [3:0] skip12;

  logic [11:0] data12;
  logic        we12;
  logic [8:0]  line12;
  logic [9:0]  pixel12;
  logic        done12;
  logic        busy12;

  logic [15:0] data16;
  logic        we16;
  logic [8:0]  line16;
  logic [9:0]  pixel16;
  logic        done16;
  logic        busy16;

  int n_checks = 0;
  int n_fail   = 0;
  int n_we12   = 0;
  int n_we16   = 0;
  int n_done12 = 0;
  int base;

  logic [63:0] exp12_q[$];
  logic [63:0] exp16_q[$];

  // Expected writes on line 1 (6 pixels, bytes 0x1k/0x2k) for RGB444.
  logic [11:0] l1_exp12 [6] = '{12'h020, 12'h121, 12'h222, 12'h323, 12'h424, 12'h525};

  // clock
  always #5 clk = ~clk;

  cam_capture_window #(
    .DATA_WIDTH(12)
  ) dut12 (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_enable     (i_enable),
    .i_vs         (i_vs),
    .i_hs         (i_hs),
    .i_data       (i_data),
`ifdef CAM_CAPTURE_FRAME_SKIP_EN
    .i_skip       (skip12),
`endif
    .o_data_wr    (data12),
    .we           (we12),
    .o_line       (line12),
    .o_pixel      (pixel12),
    .o_frame_done (done12),
    .o_busy       (busy12)
  );

  cam_capture_window #(
    .DATA_WIDTH(16),
    .X_START   (2),
    .WIN_W     (2)
  ) dut16 (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_enable     (i_enable),
    .i_vs         (i_vs),
    .i_hs         (i_hs),
    .i_data       (i_data),
`ifdef CAM_CAPTURE_FRAME_SKIP_EN
    .i_skip       (4'd0),
`endif
    .o_data_wr    (data16),
    .we           (we16),
    .o_line       (line16),
    .o_pixel      (pixel16),
    .o_frame_done (done16),
    .o_busy       (busy16)
  );

  cam_capture_window_if #(.DATA_WIDTH(16)) pk_if ();

  cam_pixel_pack #(
    .DATA_WIDTH(16)
  ) u_pack_ut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (pk_if.slave)
  );

  function automatic logic [63:0] mk12(input logic [8:0] l, input logic [9:0] p,
                                       input logic [11:0] d);
    return {33'd0, l, p, d};
  endfunction

  function automatic logic [63:0] mk16(input logic [8:0] l, input logic [9:0] p,
                                       input logic [15:0] d);
    return {29'd0, l, p, d};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of camera inputs; returns 1 time unit after the edge.
  task automatic drive_cycle(input logic vs, input logic hs, input logic [7:0] d);
    i_vs   = vs;
    i_hs   = hs;
    i_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 8'h00);
  endtask

  task automatic frame_start();
    repeat (3) drive_cycle(1'b1, 1'b0, 8'h00);
    repeat (3) drive_cycle(1'b0, 1'b0, 8'h00);
  endtask

  task automatic frame_end();
    repeat (3) drive_cycle(1'b1, 1'b0, 8'h00);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (we12 === 1'b1) begin
      n_we12++;
      if (exp12_q.size() == 0) check_eq("we12_spurious", mk12(line12, pixel12, data12), '1);
      else check_eq("wr12", mk12(line12, pixel12, data12), exp12_q.pop_front());
    end
    if (we16 === 1'b1) begin
      n_we16++;
      if (exp16_q.size() == 0) check_eq("we16_spurious", mk16(line16, pixel16, data16), '1);
      else check_eq("wr16", mk16(line16, pixel16, data16), exp16_q.pop_front());
    end
    if (done12 === 1'b1) n_done12++;
  end

  initial begin
    reset_n          = 1'b0;
    i_enable         = 1'b0;
    i_vs             = 1'b0;
    i_hs             = 1'b0;
    i_data           = 8'h00;
    skip12           = 4'd0;
    pk_if.byte_en    = 1'b0;
    pk_if.byte_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;

    // reset state
    check_eq("rst_we12", we12, 0);
    check_eq("rst_done12", done12, 0);
    check_eq("rst_busy12", busy12, 0);
    check_eq("rst_data12", data12, 0);
    check_eq("rst_line12", line12, 0);
    check_eq("rst_pixel12", pixel12, 0);
    check_eq("rst_we16", we16, 0);
    reset_n = 1'b1;
    idle(2);

    // assembler unit: 0x9A then 0x7E -> 0x9A7E in RGB565
    pk_if.byte_en   = 1'b1;
    pk_if.byte_data = 8'h9A;
    #1;
    check_eq("pack_first_byte_valid", pk_if.pix_valid, 0);
    @(posedge clk);
    #1;
    pk_if.byte_data = 8'h7E;
    #1;
    check_eq("pack_pair_valid", pk_if.pix_valid, 1);
    check_eq("pack_pair_data", pk_if.pix_data, 16'h9A7E);
    @(posedge clk);
    #1;
    pk_if.byte_en = 1'b0;
    #1;
    check_eq("pack_gap_valid", pk_if.pix_valid, 0);

    // frame 1: basic packing, cropping, odd burst
    i_enable = 1'b1;
    idle(2);
    check_eq("busy_wait_frame", busy12, 0);
    frame_start();
    check_eq("busy_in_frame", busy12, 1);

    exp12_q.push_back(mk12(9'd0, 10'd0, 12'h53C));
    drive_cycle(1'b0, 1'b1, 8'hA5);
    check_eq("we_after_high_byte", we12, 0);
    drive_cycle(1'b0, 1'b1, 8'h3C);
    check_eq("we_latency", we12, 1);
    check_eq("rgb444_data", data12, 12'h53C);
    check_eq("rgb444_pixel", pixel12, 0);
    check_eq("rgb444_line", line12, 0);
    drive_cycle(1'b0, 1'b0, 8'h00);
    check_eq("we_one_cycle", we12, 0);
    check_eq("data_hold", data12, 12'h53C);
    idle(2);

    // line 1: six pixels, RGB565 window keeps source pixels 2 and 3
    for (int k = 0; k < 6; k++) exp12_q.push_back(mk12(9'd1, 10'(k), l1_exp12[k]));
    exp16_q.push_back(mk16(9'd1, 10'd0, 16'h1222));
    exp16_q.push_back(mk16(9'd1, 10'd1, 16'h1323));
    base = n_we16;
    for (int k = 0; k < 6; k++) begin
      drive_cycle(1'b0, 1'b1, 8'h10 + 8'(k));
      drive_cycle(1'b0, 1'b1, 8'h20 + 8'(k));
    end
    drive_cycle(1'b0, 1'b0, 8'h00);
    idle(2);
    check_eq("crop_we_count", 64'(n_we16 - base), 2);

    // line 2: three-byte burst, third byte dropped
    exp12_q.push_back(mk12(9'd2, 10'd0, 12'h0B1));
    base = n_we12;
    drive_cycle(1'b0, 1'b1, 8'hB0);
    drive_cycle(1'b0, 1'b1, 8'hB1);
    drive_cycle(1'b0, 1'b1, 8'hB2);
    drive_cycle(1'b0, 1'b0, 8'h00);
    idle(2);
    check_eq("odd_burst_we_count", 64'(n_we12 - base), 1);

    // line 3 starts in phase 0
    exp12_q.push_back(mk12(9'd3, 10'd0, 12'h1C2));
    drive_cycle(1'b0, 1'b1, 8'hC1);
    drive_cycle(1'b0, 1'b1, 8'hC2);
    check_eq("phase_restart_we", we12, 1);
    check_eq("phase_restart_data", data12, 12'h1C2);
    drive_cycle(1'b0, 1'b0, 8'h00);
    idle(2);

    base = n_done12;
    drive_cycle(1'b1, 1'b0, 8'h00);
    check_eq("frame_done_pulse", done12, 1);
    check_eq("busy_after_frame", busy12, 0);
    drive_cycle(1'b1, 1'b0, 8'h00);
    check_eq("frame_done_one_cycle", done12, 0);
    drive_cycle(1'b1, 1'b0, 8'h00);
    check_eq("frame_done_count", 64'(n_done12 - base), 1);

    // frame 2: VSYNC rises while HREF high
    frame_start();
    exp12_q.push_back(mk12(9'd0, 10'd0, 12'h1D2));
    drive_cycle(1'b0, 1'b1, 8'hD1);
    drive_cycle(1'b0, 1'b1, 8'hD2);
    drive_cycle(1'b0, 1'b1, 8'hD3);
    base = n_we12;
    drive_cycle(1'b1, 1'b1, 8'hD4);
    check_eq("abort_frame_done", done12, 1);
    drive_cycle(1'b1, 1'b0, 8'h00);
    drive_cycle(1'b1, 1'b0, 8'h00);
    check_eq("abort_no_write", 64'(n_we12 - base), 0);

    // frame 3: enable dropped mid-frame
    frame_start();
    exp12_q.push_back(mk12(9'd0, 10'd0, 12'h1E2));
    drive_cycle(1'b0, 1'b1, 8'hE1);
    drive_cycle(1'b0, 1'b1, 8'hE2);
    drive_cycle(1'b0, 1'b0, 8'h00);
    i_enable = 1'b0;
    idle(2);
    exp12_q.push_back(mk12(9'd1, 10'd0, 12'h1F2));
    drive_cycle(1'b0, 1'b1, 8'hF1);
    drive_cycle(1'b0, 1'b1, 8'hF2);
    drive_cycle(1'b0, 1'b0, 8'h00);
    check_eq("busy_after_disable", busy12, 1);
    drive_cycle(1'b1, 1'b0, 8'h00);
    check_eq("disable_frame_done", done12, 1);
    drive_cycle(1'b1, 1'b0, 8'h00);
    drive_cycle(1'b1, 1'b0, 8'h00);
    frame_start();
    base = n_we12;
    drive_cycle(1'b0, 1'b1, 8'h11);
    drive_cycle(1'b0, 1'b1, 8'h22);
    drive_cycle(1'b0, 1'b0, 8'h00);
    check_eq("disabled_no_write", 64'(n_we12 - base), 0);
    check_eq("disabled_busy", busy12, 0);
    frame_end();

    // frame 4: reset mid-line
    i_enable = 1'b1;
    frame_start();
    exp12_q.push_back(mk12(9'd0, 10'd0, 12'h1A2));
    drive_cycle(1'b0, 1'b1, 8'hA1);
    drive_cycle(1'b0, 1'b1, 8'hA2);
    drive_cycle(1'b0, 1'b1, 8'hB3);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_we", we12, 0);
    check_eq("async_rst_data", data12, 0);
    check_eq("async_rst_busy", busy12, 0);
    check_eq("async_rst_line", line12, 0);
    check_eq("async_rst_pixel", pixel12, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    base = n_we12;
    drive_cycle(1'b0, 1'b1, 8'hB4);
    drive_cycle(1'b0, 1'b1, 8'hB5);
    drive_cycle(1'b0, 1'b1, 8'hB6);
    drive_cycle(1'b0, 1'b0, 8'h00);
    drive_cycle(1'b0, 1'b1, 8'hB7);
    drive_cycle(1'b0, 1'b1, 8'hB8);
    drive_cycle(1'b0, 1'b0, 8'h00);
    check_eq("post_rst_no_write", 64'(n_we12 - base), 0);
    check_eq("post_rst_busy", busy12, 0);
    frame_end();
    frame_start();
    exp12_q.push_back(mk12(9'd0, 10'd0, 12'h1C8));
    drive_cycle(1'b0, 1'b1, 8'h71);
    drive_cycle(1'b0, 1'b1, 8'hC8);
    check_eq("post_rst_resume_we", we12, 1);
    drive_cycle(1'b0, 1'b0, 8'h00);
    frame_end();

`ifdef CAM_CAPTURE_FRAME_SKIP_EN
    // skip 2: frames 0 and 3 of 6 are captured
    skip12 = 4'd2;
    base = n_done12;
    for (int f = 0; f < 6; f++) begin
      frame_start();
      if (f == 0) exp12_q.push_back(mk12(9'd0, 10'd0, 12'h070));
      if (f == 3) exp12_q.push_back(mk12(9'd0, 10'd0, 12'h373));
      check_eq("skip_busy", busy12, (f == 0 || f == 3) ? 1 : 0);
      drive_cycle(1'b0, 1'b1, 8'h60 + 8'(f));
      drive_cycle(1'b0, 1'b1, 8'h70 + 8'(f));
      drive_cycle(1'b0, 1'b0, 8'h00);
      frame_end();
    end
    check_eq("skip_done_count", 64'(n_done12 - base), 2);
    skip12 = 4'd0;
`endif

    idle(3);
    check_eq("exp12_drained", 64'(exp12_q.size()), 0);
    check_eq("exp16_drained", 64'(exp16_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
